mult_timing_leak_monitor: RTL

//   Constant-time check for LANES multiplier copies that share one start.

---
 rtl/mult_timing_leak_monitor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mult_timing_leak_monitor.sv
`default_nettype none
// mult_timing_leak_monitor: per-lane start-to-done latency capture with min/max/spread
// reporting and leak/timeout flags for a group of multiplier copies. Revision 1.0
module mult_timing_leak_monitor #(
  parameter int LANES     = 2,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LANES-1:0]     done,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 leak,
  output logic                 leak_sticky,
  output logic                 timeout,
  output logic [LANES-1:0]     done_mask,
  output logic [CNT_WIDTH-1:0] lat_min,
  output logic [CNT_WIDTH-1:0] lat_max,
  output logic [CNT_WIDTH-1:0] spread
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] lat      [LANES];
  logic [CNT_WIDTH-1:0] lat_next [LANES];
  logic [LANES-1:0]     capture;
  logic [LANES-1:0]     mask_next;
  logic [CNT_WIDTH-1:0] min_next;
  logic [CNT_WIDTH-1:0] max_next;
  logic                 any_captured;
  logic                 all_done;
  logic                 run_exit;
  logic                 timed_out;
  logic                 leak_next;

  // Only the first high of done in a run is a capture; later highs are masked off.
  always_comb begin
    capture = '0;
    if (state == RUN) capture = done & ~done_mask;
    mask_next = done_mask | capture;
    all_done  = &mask_next;
    run_exit  = (state == RUN) && (all_done || (cnt == TIMEOUT_CNT));
    timed_out = !all_done;
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lat_next[i] = capture[i] ? cnt : lat[i];
    end
  end

  // Extremes over captured lanes only, so a timed-out lane cannot pull min to 0.
  always_comb begin
    any_captured = 1'b0;
    min_next     = '0;
    max_next     = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mask_next[i]) begin
        if (!any_captured || (lat_next[i] < min_next)) min_next = lat_next[i];
        if (!any_captured || (lat_next[i] > max_next)) max_next = lat_next[i];
        any_captured = 1'b1;
      end
    end
    leak_next = timed_out || (max_next != min_next);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (run_exit) state_next = REPORT;
      end
      REPORT: begin
        result_valid = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      done_mask   <= '0;
      leak        <= 1'b0;
      leak_sticky <= 1'b0;
      timeout     <= 1'b0;
      lat_min     <= '0;
      lat_max     <= '0;
      spread      <= '0;
      for (int i = 0; i < LANES; i++) lat[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt       <= CNT_ONE;
            done_mask <= '0;
            leak      <= 1'b0;
            timeout   <= 1'b0;
            lat_min   <= '0;
            lat_max   <= '0;
            spread    <= '0;
            for (int i = 0; i < LANES; i++) lat[i] <= '0;
          end
        end
        RUN: begin
          done_mask <= mask_next;
          for (int i = 0; i < LANES; i++) lat[i] <= lat_next[i];
          if (run_exit) begin
            lat_min     <= min_next;
            lat_max     <= max_next;
            spread      <= max_next - min_next;
            timeout     <= timed_out;
            leak        <= leak_next;
            leak_sticky <= leak_sticky | leak_next;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
